multiplier_eval_sequencer: RTL

//  Exhaustive test sequencer for one candidate W x W multiplier emitted by the RL exploration flow.

---
 rtl/multiplier_eval_pkg.sv | 21 ++
 rtl/mult_golden_ref.sv | 14 +
 rtl/multiplier_eval_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/multiplier_eval_pkg.sv
// Shared types and helpers for multiplier evaluators: FSM states, golden product, vector count.
// Pure declarations; no latency, no flow control.
package multiplier_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF = 2;
  localparam int NV    = 1 << (2 * W_DEF);

  // Unsigned w x w product, truncated to 2w bits.
  function automatic logic [63:0] golden_mul(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return ({32'd0, a} * {32'd0, b}) & mask;
  endfunction

endpackage

// File: rtl/mult_golden_ref.sv
// Combinational W x W unsigned reference product; zero latency, no flow control.
module mult_golden_ref
  import multiplier_eval_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = (2*W)'(golden_mul(32'(a), 32'(b), W));

endmodule

// File: rtl/multiplier_eval_sequencer.sv
// Exhaustive sequencer scoring a candidate multiplier: every (A,B) held SETTLE cycles, then compared.
// A full run takes NV*SETTLE cycles; start is ignored while busy, abort returns to IDLE keeping results.
module multiplier_eval_sequencer
  import multiplier_eval_pkg::*;
#(
  parameter int W      = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [W-1:0]   cand_a,
  output logic [W-1:0]   cand_b,
  input  logic [2*W-1:0] cand_p,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic           fail_valid,
  output logic [W-1:0]   fail_a,
  output logic [W-1:0]   fail_b,
  output logic [2*W-1:0] fail_p
);

  localparam int VW = 2 * W;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [VW-1:0] VEC_LAST    = {VW{1'b1}};
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);

  state_t        state, state_nx;
  logic [VW-1:0] vec, vec_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [VW:0]   err_nx;
  logic          fail_valid_nx;
  logic [W-1:0]  fail_a_nx, fail_b_nx;
  logic [VW-1:0] fail_p_nx;
  logic [VW-1:0] golden;

  mult_golden_ref #(.W(W)) u_golden (
    .a (cand_a),
    .b (cand_b),
    .p (golden)
  );

  // Operands come straight from the vector register, so they are registered outputs.
  assign cand_a = vec[VW-1:W];
  assign cand_b = vec[W-1:0];
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign pass   = done && (err_cnt == '0);

  always_comb begin
    state_nx      = state;
    vec_nx        = vec;
    settle_nx     = settle_cnt;
    err_nx        = err_cnt;
    fail_valid_nx = fail_valid;
    fail_a_nx     = fail_a;
    fail_b_nx     = fail_b;
    fail_p_nx     = fail_p;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx      = RUN;
          vec_nx        = '0;
          settle_nx     = SETTLE_INIT;
          err_nx        = '0;
          fail_valid_nx = 1'b0;
          fail_a_nx     = '0;
          fail_b_nx     = '0;
          fail_p_nx     = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (settle_cnt == SW'(1)) begin
          if (cand_p != golden) begin
            err_nx = err_cnt + (VW+1)'(1);
            if (!fail_valid) begin
              fail_valid_nx = 1'b1;
              fail_a_nx     = cand_a;
              fail_b_nx     = cand_b;
              fail_p_nx     = cand_p;
            end
          end
          if (vec == VEC_LAST) begin
            state_nx = DONE;
          end else begin
            vec_nx    = vec + VW'(1);
            settle_nx = SETTLE_INIT;
          end
        end else begin
          settle_nx = settle_cnt - SW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_p     <= '0;
    end else begin
      state      <= state_nx;
      vec        <= vec_nx;
      settle_cnt <= settle_nx;
      err_cnt    <= err_nx;
      fail_valid <= fail_valid_nx;
      fail_a     <= fail_a_nx;
      fail_b     <= fail_b_nx;
      fail_p     <= fail_p_nx;
    end
  end

endmodule
